// File: rtl/thresh_axi_pkg.sv
// Shared AXI-lite definitions for the threshold loader and thresholding_axi:
// response codes, loader states and the threshold address layout.
package thresh_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WRITE,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA,
        ST_FIN
    } loader_state_t;

    // Byte address {cf, pe, t, 2'b00}; a zero-width field contributes nothing.
    function automatic logic [31:0] thresh_addr(input int unsigned cf,
                                                input int unsigned pe,
                                                input int unsigned t,
                                                input int unsigned pe_bits,
                                                input int unsigned t_bits);
        return (cf << (pe_bits + t_bits + 2)) | (pe << (t_bits + 2)) | (t << 2);
    endfunction

endpackage

// File: rtl/thresh_addr_cnt.sv
// Threshold walk counter (t fastest, then pe, then cf) with address composition.
// Shared by the write pass and the readback pass.
module thresh_addr_cnt
    import thresh_axi_pkg::*;
#(
    parameter int unsigned N         = 14,
    parameter int unsigned PE        = 2,
    parameter int unsigned CF        = 3,
    parameter int unsigned ADDR_BITS = $clog2(CF) + $clog2(PE) + $clog2(N) + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 adv_i,
    output logic [ADDR_BITS-1:0] addr_o,
    output logic                 last_o
);

    localparam int unsigned T_BITS  = $clog2(N);
    localparam int unsigned PE_BITS = $clog2(PE);
    localparam int unsigned CF_BITS = $clog2(CF);
    // Registers keep one bit even when the field is absent from the address.
    localparam int unsigned TW  = (T_BITS  > 0) ? T_BITS  : 1;
    localparam int unsigned PEW = (PE_BITS > 0) ? PE_BITS : 1;
    localparam int unsigned CFW = (CF_BITS > 0) ? CF_BITS : 1;

    logic [TW-1:0]  t_q, t_d;
    logic [PEW-1:0] pe_q, pe_d;
    logic [CFW-1:0] cf_q, cf_d;
    logic           t_wrap, pe_wrap, cf_wrap;

    assign t_wrap  = (t_q  == TW'(N - 1));
    assign pe_wrap = (pe_q == PEW'(PE - 1));
    assign cf_wrap = (cf_q == CFW'(CF - 1));
    assign last_o  = t_wrap & pe_wrap & cf_wrap;

    always_comb begin
        t_d  = t_q;
        pe_d = pe_q;
        cf_d = cf_q;
        if (clr_i) begin
            t_d  = '0;
            pe_d = '0;
            cf_d = '0;
        end else if (adv_i) begin
            t_d = t_wrap ? '0 : t_q + TW'(1);
            if (t_wrap) begin
                pe_d = pe_wrap ? '0 : pe_q + PEW'(1);
                if (pe_wrap) begin
                    cf_d = cf_wrap ? '0 : cf_q + CFW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_q  <= '0;
            pe_q <= '0;
            cf_q <= '0;
        end else begin
            t_q  <= t_d;
            pe_q <= pe_d;
            cf_q <= cf_d;
        end
    end

    assign addr_o = ADDR_BITS'(thresh_addr(32'(cf_q), 32'(pe_q), 32'(t_q), PE_BITS, T_BITS));

endmodule

// File: rtl/axilite_thresh_loader.sv
// Streams C*N thresholds into a thresholding_axi slave over AXI-lite, one
// transaction at a time, then optionally reads them back and compares XOR checksums.
module axilite_thresh_loader
    import thresh_axi_pkg::*;
#(
    parameter int unsigned N        = 14,
    parameter int unsigned C        = 6,
    parameter int unsigned PE       = 2,
    parameter int unsigned WT       = 10,
    parameter bit          READBACK = 1'b1,
    localparam int unsigned CF        = C / PE,
    localparam int unsigned ADDR_BITS = $clog2(CF) + $clog2(PE) + $clog2(N) + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [WT-1:0]        s_axis_tdata,
    output logic                 m_axilite_AWVALID,
    input  logic                 m_axilite_AWREADY,
    output logic [ADDR_BITS-1:0] m_axilite_AWADDR,
    output logic                 m_axilite_WVALID,
    input  logic                 m_axilite_WREADY,
    output logic [31:0]          m_axilite_WDATA,
    output logic [3:0]           m_axilite_WSTRB,
    input  logic                 m_axilite_BVALID,
    output logic                 m_axilite_BREADY,
    input  logic [1:0]           m_axilite_BRESP,
    output logic                 m_axilite_ARVALID,
    input  logic                 m_axilite_ARREADY,
    output logic [ADDR_BITS-1:0] m_axilite_ARADDR,
    input  logic                 m_axilite_RVALID,
    output logic                 m_axilite_RREADY,
    input  logic [31:0]          m_axilite_RDATA,
    input  logic [1:0]           m_axilite_RRESP
);

    loader_state_t        state_q, state_d;
    logic [WT-1:0]        data_q, data_d;
    logic [31:0]          cw_q, cw_d, cr_q, cr_d;
    logic                 err_q, err_d;
    logic                 awv_q, awv_d, wv_q, wv_d;
    logic                 cnt_clr, cnt_adv, cnt_last;
    logic [ADDR_BITS-1:0] cnt_addr;
    logic                 unused_rdata;

    // Only RDATA[WT-1:0] carries threshold bits.
    assign unused_rdata = ^m_axilite_RDATA;

    thresh_addr_cnt #(
        .N        (N),
        .PE       (PE),
        .CF       (CF),
        .ADDR_BITS(ADDR_BITS)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .adv_i (cnt_adv),
        .addr_o(cnt_addr),
        .last_o(cnt_last)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cw_d    = cw_q;
        cr_d    = cr_q;
        err_d   = err_q;
        awv_d   = awv_q;
        wv_d    = wv_q;
        cnt_clr = 1'b0;
        cnt_adv = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    cw_d    = '0;
                    cr_d    = '0;
                    cnt_clr = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (s_axis_tvalid) begin
                    data_d  = s_axis_tdata;
                    cw_d    = cw_q ^ 32'(s_axis_tdata);
                    awv_d   = 1'b1;
                    wv_d    = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // AW and W complete independently; leave once neither is outstanding.
                awv_d = awv_q & ~m_axilite_AWREADY;
                wv_d  = wv_q & ~m_axilite_WREADY;
                if (!awv_d && !wv_d) begin
                    state_d = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (m_axilite_BVALID) begin
                    if (m_axilite_BRESP != RESP_OKAY) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else if (cnt_last) begin
                        if (READBACK) begin
                            cnt_clr = 1'b1;
                            state_d = ST_RADDR;
                        end else begin
                            state_d = ST_FIN;
                        end
                    end else begin
                        cnt_adv = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_RADDR: begin
                if (m_axilite_ARREADY) begin
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (m_axilite_RVALID) begin
                    if (m_axilite_RRESP != RESP_OKAY) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        cr_d = cr_q ^ 32'(m_axilite_RDATA[WT-1:0]);
                        if (cnt_last) begin
                            err_d   = (cr_d != cw_q);
                            state_d = ST_FIN;
                        end else begin
                            cnt_adv = 1'b1;
                            state_d = ST_RADDR;
                        end
                    end
                end
            end
            ST_FIN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cw_q    <= '0;
            cr_q    <= '0;
            err_q   <= 1'b0;
            awv_q   <= 1'b0;
            wv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cw_q    <= cw_d;
            cr_q    <= cr_d;
            err_q   <= err_d;
            awv_q   <= awv_d;
            wv_q    <= wv_d;
        end
    end

    assign busy              = (state_q != ST_IDLE);
    assign done              = (state_q == ST_FIN);
    assign err               = err_q;
    assign s_axis_tready     = (state_q == ST_FETCH);
    assign m_axilite_AWVALID = awv_q;
    assign m_axilite_AWADDR  = cnt_addr;
    assign m_axilite_WVALID  = wv_q;
    assign m_axilite_WDATA   = 32'(data_q);
    assign m_axilite_WSTRB   = '1;
    assign m_axilite_BREADY  = (state_q == ST_WRESP);
    assign m_axilite_ARVALID = (state_q == ST_RADDR);
    assign m_axilite_ARADDR  = cnt_addr;
    assign m_axilite_RREADY  = (state_q == ST_RDATA);

endmodule

// File: tb/tb_axilite_thresh_loader.sv
// Scoreboard bench: expected writes/reads are queued per run; the AXI-lite slave
// models pop and compare at each completed transaction.
`timescale 1ns/1ps
module tb_axilite_thresh_loader;

    localparam int NI  = 84;
    localparam int AB  = 9;
    localparam int NI2 = 8;
    localparam int AB2 = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done, err;
    logic tvalid = 1'b0, tready;
    logic [9:0] tdata = '0;
    logic awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [AB-1:0] awaddr, araddr;
    logic [31:0] wdata, rdata = '0;
    logic [3:0] wstrb;
    logic bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;
    logic [1:0] bresp = '0, rresp = '0;

    logic b_start = 1'b0, b_busy, b_done, b_err;
    logic b_tvalid = 1'b0, b_tready;
    logic [9:0] b_tdata = '0;
    logic b_awvalid, b_awready = 1'b0, b_wvalid, b_wready = 1'b0;
    logic [AB2-1:0] b_awaddr, b_araddr;
    logic [31:0] b_wdata;
    logic [3:0] b_wstrb;
    logic b_bvalid = 1'b0, b_bready, b_arvalid, b_rready;
    logic b_arready = 1'b0, b_rvalid = 1'b0;
    logic [31:0] b_rdata = '0;
    logic [1:0] b_bresp = '0, b_rresp = '0;

    axilite_thresh_loader dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tdata(tdata),
        .m_axilite_AWVALID(awvalid), .m_axilite_AWREADY(awready), .m_axilite_AWADDR(awaddr),
        .m_axilite_WVALID(wvalid), .m_axilite_WREADY(wready), .m_axilite_WDATA(wdata),
        .m_axilite_WSTRB(wstrb), .m_axilite_BVALID(bvalid), .m_axilite_BREADY(bready),
        .m_axilite_BRESP(bresp), .m_axilite_ARVALID(arvalid), .m_axilite_ARREADY(arready),
        .m_axilite_ARADDR(araddr), .m_axilite_RVALID(rvalid), .m_axilite_RREADY(rready),
        .m_axilite_RDATA(rdata), .m_axilite_RRESP(rresp)
    );

    axilite_thresh_loader #(.N(4), .C(2), .PE(1), .WT(10), .READBACK(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done), .err(b_err),
        .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready), .s_axis_tdata(b_tdata),
        .m_axilite_AWVALID(b_awvalid), .m_axilite_AWREADY(b_awready), .m_axilite_AWADDR(b_awaddr),
        .m_axilite_WVALID(b_wvalid), .m_axilite_WREADY(b_wready), .m_axilite_WDATA(b_wdata),
        .m_axilite_WSTRB(b_wstrb), .m_axilite_BVALID(b_bvalid), .m_axilite_BREADY(b_bready),
        .m_axilite_BRESP(b_bresp), .m_axilite_ARVALID(b_arvalid), .m_axilite_ARREADY(b_arready),
        .m_axilite_ARADDR(b_araddr), .m_axilite_RVALID(b_rvalid), .m_axilite_RREADY(b_rready),
        .m_axilite_RDATA(b_rdata), .m_axilite_RRESP(b_rresp)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic [9:0] vals [NI];
    wr_t        exp_q[$];
    logic [31:0] exp_rd_q[$];
    logic [AB-1:0] aw_log[$];
    wr_t        b_exp_q[$];
    logic [AB2-1:0] b_log[$];

    // Slave A configuration: 0 always ready, 1 throttled, 2 AW/W stalled
    int mode = 0;
    int bresp_err_at = -1;
    int corrupt_at = -1;
    int aw_cnt = 0, wr_cnt = 0, rd_cnt = 0, b_wr_cnt = 0;
    bit b_ar_seen = 1'b0;

    logic [31:0] mem [128];
    bit aw_done = 0, w_done = 0, ar_done = 0;
    logic [AB-1:0] aw_addr_c = '0, ar_addr_c = '0;
    logic [31:0] w_data_c = '0;
    int aw_age = 0;
    bit p_awv = 0, p_aws = 0, p_wv = 0, p_ws = 0, p_arv = 0, p_ars = 0;
    logic [AB-1:0] p_awa = '0, p_ara = '0;
    logic [31:0] p_wd = '0;

    always @(negedge clk) begin : slave_a
        wr_t e;
        if (rst) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            aw_done = 0; w_done = 0; ar_done = 0;
            p_awv = 0; p_aws = 0; p_wv = 0; p_ws = 0; p_arv = 0; p_ars = 0;
        end else begin
            if (p_awv && !p_aws) begin
                check("awvalid_hold", awvalid, 1);
                check("awaddr_hold", awaddr, p_awa);
            end
            if (p_wv && !p_ws) begin
                check("wvalid_hold", wvalid, 1);
                check("wdata_hold", wdata, p_wd);
            end
            if (p_arv && !p_ars) begin
                check("arvalid_hold", arvalid, 1);
                check("araddr_hold", araddr, p_ara);
            end
            if ((aw_done && w_done) || ar_done)
                check("issue_while_pending", {awvalid, wvalid, arvalid}, 0);

            awready = !aw_done && (mode == 0 || (mode == 1 && $urandom_range(0, 2) == 0));
            wready  = !w_done && (mode == 0 || (mode == 1 && aw_done && aw_age >= 3));
            bvalid  = aw_done && w_done;
            bresp   = (wr_cnt == bresp_err_at) ? 2'b10 : 2'b00;
            arready = !ar_done && (mode != 1 || $urandom_range(0, 1) == 0);
            rvalid  = ar_done;
            rdata   = mem[ar_addr_c[AB-1:2]] ^ ((rd_cnt == corrupt_at) ? 32'h4 : 32'h0);
            rresp   = 2'b00;

            // Handshakes below complete at the coming posedge.
            p_awv = awvalid; p_aws = awvalid && awready; p_awa = awaddr;
            p_wv = wvalid; p_ws = wvalid && wready; p_wd = wdata;
            p_arv = arvalid; p_ars = arvalid && arready; p_ara = araddr;
            if (awvalid && awready) begin
                aw_done = 1; aw_addr_c = awaddr; aw_age = 0; aw_cnt++;
                aw_log.push_back(awaddr);
            end else if (aw_done && !w_done) begin
                aw_age++;
            end
            if (wvalid && wready) begin
                w_done = 1; w_data_c = wdata;
                check("wstrb", wstrb, 4'hf);
            end
            if (bvalid && bready) begin
                mem[aw_addr_c[AB-1:2]] = w_data_c;
                aw_done = 0; w_done = 0; wr_cnt++;
                if (exp_q.size() == 0) check("unexpected_write", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("write_addr", aw_addr_c, e.addr);
                    check("write_data", w_data_c, e.data);
                end
            end
            if (arvalid && arready) begin
                ar_done = 1; ar_addr_c = araddr;
            end
            if (rvalid && rready) begin
                ar_done = 0; rd_cnt++;
                if (exp_rd_q.size() == 0) check("unexpected_read", 1, 0);
                else check("read_addr", ar_addr_c, exp_rd_q.pop_front());
            end
        end
    end

    bit baw_done = 0, bw_done = 0;
    logic [AB2-1:0] baw_a = '0;
    logic [31:0] bw_d = '0;

    always @(negedge clk) begin : slave_b
        wr_t e;
        if (rst) begin
            b_awready = 0; b_wready = 0; b_bvalid = 0;
            baw_done = 0; bw_done = 0;
        end else begin
            b_awready = !baw_done;
            b_wready  = !bw_done;
            b_bvalid  = baw_done && bw_done;
            if (b_arvalid) b_ar_seen = 1'b1;
            if (b_awvalid && b_awready) begin
                baw_done = 1; baw_a = b_awaddr; b_log.push_back(b_awaddr);
            end
            if (b_wvalid && b_wready) begin
                bw_done = 1; bw_d = b_wdata;
            end
            if (b_bvalid && b_bready) begin
                baw_done = 0; bw_done = 0; b_wr_cnt++;
                if (b_exp_q.size() == 0) check("b_unexpected_write", 1, 0);
                else begin
                    e = b_exp_q.pop_front();
                    check("b_write_addr", baw_a, e.addr);
                    check("b_write_data", bw_d, e.data);
                end
            end
        end
    end

    // Hand-derived layout for N=14, PE=2: {cf[1:0], pe, t[3:0], 2'b00}
    task automatic prep_a();
        int c, t;
        wr_t e;
        exp_q.delete(); exp_rd_q.delete(); aw_log.delete();
        aw_cnt = 0; wr_cnt = 0; rd_cnt = 0;
        for (int i = 0; i < NI; i++) begin
            c = i / 14;
            t = i % 14;
            e.addr = ((c / 2) << 7) | ((c % 2) << 6) | (t << 2);
            e.data = {22'h0, vals[i]};
            exp_q.push_back(e);
            exp_rd_q.push_back(e.addr);
        end
    endtask

    task automatic offer_a(inout int idx, input int n);
        tvalid = (idx < n);
        tdata  = (idx < n) ? vals[idx] : '0;
        if (tvalid && tready) idx++;
    endtask

    task automatic run_a(input bit glitch, output int consumed, output int done_cnt,
                         output logic err_at_done);
        int idx = 0;
        int cyc = 0;
        done_cnt = 0;
        err_at_done = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (done_cnt == 0 && cyc < 6000) begin
            offer_a(idx, NI);
            start = glitch && (cyc == 40);
            if (done) begin
                done_cnt++;
                err_at_done = err;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        if (done_cnt == 0) check("run_timeout", 0, 1);
        for (int k = 0; k < 16; k++) begin
            offer_a(idx, NI);
            if (done) done_cnt++;
            @(negedge clk);
        end
        tvalid = 1'b0;
        consumed = idx;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int consumed, dcnt, idx, cyc;
        logic eflag;
        wr_t e;

        vals[0] = 10'h3ff;
        vals[1] = 10'h000;
        for (int i = 2; i < NI; i++) vals[i] = 10'((i * 97 + 13) % 1024);

        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, err, awvalid, wvalid, arvalid, bready, rready, tready}, 0);
        check("reset_outputs_b", {b_busy, b_done, b_err, b_awvalid, b_wvalid, b_tready}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Always-ready slave, full write + readback
        mode = 0; prep_a();
        run_a(1'b0, consumed, dcnt, eflag);
        check("basic_done_pulses", dcnt, 1);
        check("basic_err", eflag, 0);
        check("basic_aw_count", aw_cnt, NI);
        check("basic_writes", wr_cnt, NI);
        check("basic_reads", rd_cnt, NI);
        check("basic_consumed", consumed, NI);
        check("basic_exp_left", exp_q.size() + exp_rd_q.size(), 0);
        check("addr_ch0", aw_log[0], 9'h000);
        check("addr_ch1", aw_log[14], 9'h040);
        check("addr_ch2", aw_log[28], 9'h080);
        check("addr_last", aw_log[83], 9'h174);
        check("basic_idle", busy, 0);

        // Throttled AW/W/AR
        mode = 1; prep_a();
        run_a(1'b0, consumed, dcnt, eflag);
        check("thr_done_pulses", dcnt, 1);
        check("thr_err", eflag, 0);
        check("thr_aw_count", aw_cnt, NI);
        check("thr_writes", wr_cnt, NI);
        check("thr_reads", rd_cnt, NI);
        check("thr_exp_left", exp_q.size() + exp_rd_q.size(), 0);

        // SLVERR on the third write
        mode = 0; bresp_err_at = 2; prep_a();
        run_a(1'b0, consumed, dcnt, eflag);
        check("bresp_done_pulses", dcnt, 1);
        check("bresp_err", eflag, 1);
        check("bresp_aw_count", aw_cnt, 3);
        check("bresp_consumed", consumed, 3);
        check("bresp_reads", rd_cnt, 0);
        check("bresp_err_sticky", err, 1);
        bresp_err_at = -1;

        // Corrupted readback data on read 17
        corrupt_at = 16; prep_a();
        run_a(1'b0, consumed, dcnt, eflag);
        check("corrupt_done_pulses", dcnt, 1);
        check("corrupt_err", eflag, 1);
        check("corrupt_writes", wr_cnt, NI);
        check("corrupt_reads", rd_cnt, NI);
        corrupt_at = -1;

        // Reset while the write address is stalled
        mode = 2; prep_a();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0; cyc = 0;
        while (!awvalid && cyc < 50) begin
            offer_a(idx, NI);
            cyc++;
            @(negedge clk);
        end
        check("rst_reached_write", {awvalid, wvalid}, 2'b11);
        tvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_write", {awvalid, wvalid, busy, done, err, arvalid, tready}, 0);
        @(negedge clk);
        rst = 1'b0;
        mode = 0;
        @(negedge clk);
        prep_a();
        run_a(1'b0, consumed, dcnt, eflag);
        check("restart_first_addr", aw_log[0], 9'h000);
        check("restart_writes", wr_cnt, NI);
        check("restart_err", eflag, 0);

        // start pulsed while busy is ignored
        prep_a();
        run_a(1'b1, consumed, dcnt, eflag);
        check("glitch_done_pulses", dcnt, 1);
        check("glitch_writes", wr_cnt, NI);
        check("glitch_reads", rd_cnt, NI);
        check("glitch_err", eflag, 0);

        // C=2, PE=1, N=4, no readback: address {cf, t[1:0], 2'b00}
        b_exp_q.delete(); b_log.delete(); b_wr_cnt = 0;
        for (int i = 0; i < NI2; i++) begin
            e.addr = ((i / 4) << 4) | ((i % 4) << 2);
            e.data = {22'h0, vals[i + 5]};
            b_exp_q.push_back(e);
        end
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        idx = 0; cyc = 0; dcnt = 0; eflag = 1'b0;
        while (cyc < 400) begin
            b_tvalid = (idx < NI2);
            b_tdata  = (idx < NI2) ? vals[idx + 5] : '0;
            if (b_tvalid && b_tready) idx++;
            if (b_done) begin
                dcnt++;
                eflag = b_err;
            end
            cyc++;
            @(negedge clk);
            if (dcnt != 0 && cyc > 20 && !b_busy) break;
        end
        b_tvalid = 1'b0;
        check("b_done_pulses", dcnt, 1);
        check("b_err", eflag, 0);
        check("b_writes", b_wr_cnt, NI2);
        check("b_no_reads", b_ar_seen, 0);
        check("b_addr_cf1", b_log[4], 5'h10);
        check("b_addr_last", b_log[7], 5'h1c);
        check("b_exp_left", b_exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axilite_thresh_loader.md
AXILITE_THRESH_LOADER -- requirements
Module: axilite_thresh_loader

Interface
REQ-001 SHALL have parameter N, default 14, number of thresholds per channel.
REQ-002 SHALL have parameter C, default 6, number of channels.
REQ-003 SHALL have parameter PE, default 2, processing elements per fold; C % PE == 0.
REQ-004 SHALL have parameter WT, default 10, threshold width in bits, 1..32.
REQ-005 SHALL have parameter READBACK, default 1, which enables the verification readback pass.
REQ-006 SHALL derive CF = C/PE and ADDR_BITS = $clog2(CF)+$clog2(PE)+$clog2(N)+2 as localparams.
REQ-007 SHALL have ports, in this order:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  begin load sequence (sampled in IDLE only)
busy  out  1  sequence in progress
done  out  1  one-cycle completion pulse
err  out  1  sticky error flag, cleared on accepted start
s_axis_tvalid/tready/tdata  in/out/in  1/1/WT  threshold values, channel-major, threshold index fastest
m_axilite_AWVALID/AWREADY/AWADDR  out/in/out  1/1/ADDR_BITS  write address
m_axilite_WVALID/WREADY/WDATA/WSTRB  out/in/out/out  1/1/32/4  write data, WDATA zero-extended from WT, WSTRB='1
m_axilite_BVALID/BREADY/BRESP  in/out/in  1/1/2  write response
m_axilite_ARVALID/ARREADY/ARADDR  out/in/out  1/1/ADDR_BITS  read address
m_axilite_RVALID/RREADY/RDATA/RRESP  in/out/in/in  1/1/32/2  read data

Function
REQ-008 SHALL implement FSM states IDLE, FETCH, WRITE, WRESP, RADDR, RDATA, FIN.
REQ-009 IDLE: start=1 SHALL clear err and all counters and go to FETCH; in all other states start SHALL be ignored.
REQ-010 FETCH: tready=1; on tvalid&tready SHALL latch tdata, XOR it into 32-bit checksum CW, and go to WRITE.
REQ-011 WRITE: SHALL assert AWVALID and WVALID together on state entry; each SHALL drop independently after its own handshake; when both handshakes are complete, go to WRESP.
REQ-012 WRESP: BREADY=1; on BVALID, BRESP!=0 SHALL set err and go to FIN; otherwise advance counters and go to FETCH, or, after the last item, go to RADDR (READBACK=1) or FIN.
REQ-013 Counters t (0..N-1, fastest), pe (0..PE-1), cf (0..CF-1) SHALL each wrap to 0 and carry into the next counter.
REQ-014 Address SHALL be {cf, pe, t, 2'b00}; a field SHALL be omitted when its width is 0 (CF==1 or PE==1); unused upper bits SHALL be 0.
REQ-015 RADDR/RDATA SHALL re-walk all C*N addresses in the same order: ARVALID held until ARREADY, then RREADY=1 until RVALID; RDATA[WT-1:0] SHALL be XORed into CR.
REQ-016 RRESP!=0 SHALL set err and go to FIN; after the last read, CR!=CW SHALL set err.
REQ-017 FIN: done=1 for exactly one cycle, then IDLE. busy SHALL be 1 in every state except IDLE.
REQ-018 Outstanding transactions SHALL be at most one; no AW/W/AR is issued while a response is pending.
REQ-019 VALID signals SHALL NOT drop before their handshake; ADDR/DATA SHALL be stable while VALID is high.
REQ-020 On error, no further AW/W/AR SHALL be issued, and no further stream beats SHALL be consumed.

Reset
REQ-021 rst SHALL force IDLE, with busy=done=err=0, all VALID/READY outputs 0, and counters/CW/CR=0 on the next edge, including mid-transaction.
REQ-022 Address/data outputs MAY be don't-care while their VALID=0.

Structure
REQ-023 A shared package thresh_axi_pkg SHALL hold the AXI-lite RESP codes (OKAY=2'b00) and the address-field layout function used by both this block and thresholding_axi.
REQ-024 One sub-module, thresh_addr_cnt (the t/pe/cf counter plus address composition), is natural and SHALL be reused for the write and readback passes.

Verification
REQ-025 N=14,C=6,PE=2, slave always ready, OKAY responses: SHALL produce 84 writes; the first three distinct channel starts at AWADDR 0x000, 0x040, 0x080; the last at 0x174; done pulses once; err=0.
REQ-026 Randomly throttled AWREADY/WREADY (AW accepted 3 cycles before W): SHALL complete exactly one write per item, hold VALID/ADDR stable, and keep WVALID high until its handshake.
REQ-027 BRESP=2'b10 on the 3rd write: SHALL set err=1, pulse done, issue no 4th AW, and leave s_axis_tready low thereafter.
REQ-028 Loopback into thresholding_axi with READBACK=1: SHALL produce 84 reads, CR==CW, err=0; with a corrupted RDATA bit on read 17, SHALL set err=1 at FIN.
REQ-029 rst asserted while in WRITE with AWVALID=1: SHALL show AWVALID=WVALID=busy=0 the next cycle; a new start SHALL then restart from address 0x000.
REQ-030 start pulsed while busy: SHALL be ignored; C=2, PE=1, CF=2, N=4 SHALL yield addresses {cf,t,2'b00} with no PE field.
